// File: rtl/anfl_tex_texel_unpacker.sv
// Streaming texel unpacker: takes one packed texture memory word and emits
// its selected texels as RGBA8888, up to LANES texels per output beat.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   in_valid      input word valid
//   in_ready      unpacker accepts a word this cycle
//   in_data       packed texel word, texel 0 in the LSBs
//   in_format     format code: [1:0] class, [4:2] subtype
//   in_first      index of the first texel to emit
//   in_count      number of texels to emit (0 legal)
//   out_valid     output beat valid
//   out_ready     downstream accepts the beat
//   out_rgba      lane k in [32k+31:32k], {A,B,G,R}
//   out_lane_en   per-lane valid mask, packed from lane 0
//   out_last      final beat of the current word
//   out_err       unsupported format or clamped range (held for the word)
module anfl_tex_texel_unpacker #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned LANES  = 1,
  parameter int unsigned IDX_W  = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  input  logic [4:0]          in_format,
  input  logic [IDX_W-1:0]    in_first,
  input  logic [IDX_W-1:0]    in_count,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [32*LANES-1:0] out_rgba,
  output logic [LANES-1:0]    out_lane_en,
  output logic                out_last,
  output logic                out_err
);

  localparam int unsigned CNT_W = IDX_W + 1;
  localparam int unsigned OUT_W = 32 * LANES;
  localparam logic [CNT_W-1:0] LANES_C = CNT_W'(LANES);

  typedef enum logic [3:0] {
    K_RGB24, K_RGBA32, K_RGB565, K_RGBA4444,
    K_RGB555, K_RGBA1555, K_R8, K_R16, K_BAD
  } kind_e;

  typedef enum logic {IDLE, EMIT} state_e;

  // Format code to internal texel kind; tiled variants share the linear decode.
  function automatic kind_e fmt_kind(input logic [4:0] f);
    case (f)
      5'b00000, 5'b00011: fmt_kind = K_RGB24;
      5'b00100, 5'b00111: fmt_kind = K_RGBA32;
      5'b00001, 5'b01011: fmt_kind = K_RGB565;
      5'b00101, 5'b01111: fmt_kind = K_RGBA4444;
      5'b01001:           fmt_kind = K_RGB555;
      5'b01101:           fmt_kind = K_RGBA1555;
      5'b10011:           fmt_kind = K_R8;
      5'b10111:           fmt_kind = K_R16;
      default:            fmt_kind = K_BAD;
    endcase
  endfunction

  function automatic int unsigned kind_bpp(input kind_e k);
    case (k)
      K_RGB24:  kind_bpp = 24;
      K_RGBA32: kind_bpp = 32;
      K_R8:     kind_bpp = 8;
      K_BAD:    kind_bpp = 32;
      default:  kind_bpp = 16;
    endcase
  endfunction

  // Texels that fit in one word; zero for unsupported formats so any
  // first index lands out of range.
  function automatic logic [CNT_W-1:0] kind_cap(input kind_e k);
    if (k == K_BAD) kind_cap = '0;
    else            kind_cap = CNT_W'(DATA_W / kind_bpp(k));
  endfunction

  function automatic logic [31:0] texel_field(input logic [DATA_W-1:0] w,
                                              input kind_e k,
                                              input logic [CNT_W-1:0] t);
    texel_field = 32'(w >> (32'(t) * kind_bpp(k)));
  endfunction

  // Expand one texel field to {A,B,G,R}; narrow channels replicate their MSBs.
  function automatic logic [31:0] decode(input kind_e k, input logic [31:0] v);
    logic [7:0] r, g, b, a;
    r = '0; g = '0; b = '0; a = 8'hFF;
    case (k)
      K_RGB24:    begin r = v[7:0]; g = v[15:8]; b = v[23:16]; end
      K_RGBA32:   begin r = v[7:0]; g = v[15:8]; b = v[23:16]; a = v[31:24]; end
      K_RGB565:   begin
        r = {v[4:0], v[4:2]}; g = {v[10:5], v[10:9]}; b = {v[15:11], v[15:13]};
      end
      K_RGBA4444: begin
        r = {v[3:0], v[3:0]}; g = {v[7:4], v[7:4]};
        b = {v[11:8], v[11:8]}; a = {v[15:12], v[15:12]};
      end
      K_RGB555:   begin
        r = {v[4:0], v[4:2]}; g = {v[9:5], v[9:7]}; b = {v[14:10], v[14:12]};
      end
      K_RGBA1555: begin
        r = {v[4:0], v[4:2]}; g = {v[9:5], v[9:7]}; b = {v[14:10], v[14:12]};
        a = {8{v[15]}};
      end
      K_R8:       r = v[7:0];
      K_R16:      r = v[15:8];
      default:    a = '0;
    endcase
    decode = {a, b, g, r};
  endfunction

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   word_q, word_d;
  kind_e               kind_q, kind_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [IDX_W-1:0]    rem_q, rem_d;
  logic                err_q, err_d;
  logic                out_valid_q, out_valid_d;
  logic [OUT_W-1:0]    out_rgba_q, out_rgba_d;
  logic [LANES-1:0]    out_lane_en_q, out_lane_en_d;
  logic                out_last_q, out_last_d;
  logic                out_err_q, out_err_d;

  kind_e               kind_c;
  logic [CNT_W-1:0]    cap_c, first_c, sum_c, eff_c;
  logic                bad_c, clamp_c;
  logic                last_c, fire_c, accept_c;
  logic                load_c, clear_c;
  logic [OUT_W-1:0]    beat_rgba_c;
  logic [LANES-1:0]    beat_en_c;
  logic [CNT_W-1:0]    tex_c;

  // The beat on the output is the last one once no more than LANES remain.
  assign last_c   = CNT_W'(rem_q) <= LANES_C;
  assign fire_c   = out_valid_q && out_ready;
  assign in_ready = (state_q == IDLE) || ((state_q == EMIT) && out_ready && last_c);
  assign accept_c = in_valid && in_ready;

  // Range check and count clamp for the word on the input port.
  always_comb begin
    kind_c  = fmt_kind(in_format);
    cap_c   = kind_cap(kind_c);
    first_c = {1'b0, in_first};
    sum_c   = first_c + {1'b0, in_count};
    bad_c   = (kind_c == K_BAD) || (first_c >= cap_c);
    clamp_c = sum_c > cap_c;
    eff_c   = clamp_c ? (cap_c - first_c) : {1'b0, in_count};
  end

  // Next-state: accept a word, advance a beat, or retire the word.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    kind_d  = kind_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    err_d   = err_q;
    load_c  = 1'b0;
    clear_c = 1'b0;
    if (accept_c) begin
      word_d = in_data;
      kind_d = kind_c;
      err_d  = bad_c || clamp_c;
      if (bad_c) begin
        // Remaining of zero yields a single empty, last beat.
        idx_d   = '0;
        rem_d   = '0;
        load_c  = 1'b1;
        state_d = EMIT;
      end else if (eff_c == '0) begin
        clear_c = 1'b1;
        state_d = IDLE;
      end else begin
        idx_d   = in_first;
        rem_d   = IDX_W'(eff_c);
        load_c  = 1'b1;
        state_d = EMIT;
      end
    end else if (fire_c) begin
      if (last_c) begin
        clear_c = 1'b1;
        state_d = IDLE;
      end else begin
        idx_d  = IDX_W'(CNT_W'(idx_q) + LANES_C);
        rem_d  = rem_q - IDX_W'(LANES);
        load_c = 1'b1;
      end
    end
  end

  // Build the beat that follows from the next index/remaining values.
  always_comb begin
    beat_rgba_c = '0;
    beat_en_c   = '0;
    tex_c       = '0;
    for (int k = 0; k < LANES; k++) begin
      if (CNT_W'(k) < CNT_W'(rem_d)) begin
        tex_c                = CNT_W'(idx_d) + CNT_W'(k);
        beat_en_c[k]         = 1'b1;
        beat_rgba_c[32*k +: 32] = decode(kind_d, texel_field(word_d, kind_d, tex_c));
      end
    end
  end

  // Output registers load a new beat, clear when idle, else hold (stall).
  always_comb begin
    out_valid_d   = out_valid_q;
    out_rgba_d    = out_rgba_q;
    out_lane_en_d = out_lane_en_q;
    out_last_d    = out_last_q;
    out_err_d     = out_err_q;
    if (load_c) begin
      out_valid_d   = 1'b1;
      out_rgba_d    = beat_rgba_c;
      out_lane_en_d = beat_en_c;
      out_last_d    = CNT_W'(rem_d) <= LANES_C;
      out_err_d     = err_d;
    end else if (clear_c) begin
      out_valid_d   = 1'b0;
      out_rgba_d    = '0;
      out_lane_en_d = '0;
      out_last_d    = 1'b0;
      out_err_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      word_q        <= '0;
      kind_q        <= K_BAD;
      idx_q         <= '0;
      rem_q         <= '0;
      err_q         <= 1'b0;
      out_valid_q   <= 1'b0;
      out_rgba_q    <= '0;
      out_lane_en_q <= '0;
      out_last_q    <= 1'b0;
      out_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      word_q        <= word_d;
      kind_q        <= kind_d;
      idx_q         <= idx_d;
      rem_q         <= rem_d;
      err_q         <= err_d;
      out_valid_q   <= out_valid_d;
      out_rgba_q    <= out_rgba_d;
      out_lane_en_q <= out_lane_en_d;
      out_last_q    <= out_last_d;
      out_err_q     <= out_err_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_rgba    = out_rgba_q;
  assign out_lane_en = out_lane_en_q;
  assign out_last    = out_last_q;
  assign out_err     = out_err_q;

endmodule

// File: tb/tb_anfl_tex_texel_unpacker.sv
// Scoreboard bench for anfl_tex_texel_unpacker with DATA_W=128, LANES=4.
module tb_anfl_tex_texel_unpacker;

  localparam int unsigned DATA_W = 128;
  localparam int unsigned LANES  = 4;
  localparam int unsigned IDX_W  = 5;

  typedef struct {
    logic [127:0] rgba;
    logic [3:0]   en;
    logic         last;
    logic         err;
  } beat_t;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [DATA_W-1:0]  in_data = '0;
  logic [4:0]         in_format = '0;
  logic [IDX_W-1:0]   in_first = '0;
  logic [IDX_W-1:0]   in_count = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [32*LANES-1:0] out_rgba;
  logic [LANES-1:0]   out_lane_en;
  logic               out_last;
  logic               out_err;

  int    checks = 0;
  int    errors = 0;
  int    beat_no = 0;
  beat_t sb[$];

  anfl_tex_texel_unpacker #(.DATA_W(DATA_W), .LANES(LANES), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_format(in_format), .in_first(in_first), .in_count(in_count),
    .out_valid(out_valid), .out_ready(out_ready), .out_rgba(out_rgba),
    .out_lane_en(out_lane_en), .out_last(out_last), .out_err(out_err)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] exp_texel(input logic [4:0] f, input logic [31:0] v);
    logic [7:0] r, g, b, a;
    r = 8'h00; g = 8'h00; b = 8'h00; a = 8'hFF;
    case (f)
      5'b00000, 5'b00011: begin r = v[7:0]; g = v[15:8]; b = v[23:16]; end
      5'b00100, 5'b00111: begin r = v[7:0]; g = v[15:8]; b = v[23:16]; a = v[31:24]; end
      5'b00001, 5'b01011: begin r = {v[4:0], v[4:2]}; g = {v[10:5], v[10:9]}; b = {v[15:11], v[15:13]}; end
      5'b00101, 5'b01111: begin r = {2{v[3:0]}}; g = {2{v[7:4]}}; b = {2{v[11:8]}}; a = {2{v[15:12]}}; end
      5'b01001: begin r = {v[4:0], v[4:2]}; g = {v[9:5], v[9:7]}; b = {v[14:10], v[14:12]}; end
      5'b01101: begin r = {v[4:0], v[4:2]}; g = {v[9:5], v[9:7]}; b = {v[14:10], v[14:12]}; a = {8{v[15]}}; end
      5'b10011: r = v[7:0];
      5'b10111: r = v[15:8];
      default: a = 8'h00;
    endcase
    return {a, b, g, r};
  endfunction

  // Reference model: expected beats for one accepted word.
  task automatic push_expected(input logic [127:0] w, input logic [4:0] f, input int first, input int count);
    int bpp, cap, n;
    logic e;
    logic [127:0] sh;
    beat_t bt;
    case (f)
      5'b00000, 5'b00011: bpp = 24;
      5'b00100, 5'b00111: bpp = 32;
      5'b00001, 5'b01011, 5'b00101, 5'b01111, 5'b01001, 5'b01101, 5'b10111: bpp = 16;
      5'b10011: bpp = 8;
      default: bpp = 0;
    endcase
    cap = (bpp == 0) ? 0 : 128 / bpp;
    if (bpp == 0 || first >= cap) begin
      bt.rgba = '0; bt.en = 4'b0000; bt.last = 1'b1; bt.err = 1'b1;
      sb.push_back(bt);
      return;
    end
    n = count; e = 1'b0;
    if (first + count > cap) begin n = cap - first; e = 1'b1; end
    for (int b = 0; b < n; b += 4) begin
      bt.rgba = '0; bt.en = 4'b0000;
      for (int k = 0; k < 4; k++) begin
        if (b + k < n) begin
          sh = w >> ((first + b + k) * bpp);
          bt.rgba[32*k +: 32] = exp_texel(f, sh[31:0]);
          bt.en[k] = 1'b1;
        end
      end
      bt.last = (b + 4 >= n);
      bt.err  = e;
      sb.push_back(bt);
    end
  endtask

  // Monitor: pops the scoreboard on each output handshake and checks stall stability.
  logic         stall_prev = 1'b0;
  logic [134:0] held;
  always @(negedge clk) begin
    beat_t exp_b;
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        checks++;
        if ({out_valid, out_rgba, out_lane_en, out_last, out_err} !== held) begin
          errors++;
          $display("FAIL stall_hold got %h want %h", {out_valid, out_rgba, out_lane_en, out_last, out_err}, held);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL beat%0d unexpected beat rgba=%h en=%b", beat_no, out_rgba, out_lane_en);
        end else begin
          exp_b = sb.pop_front();
          if (out_rgba !== exp_b.rgba || out_lane_en !== exp_b.en || out_last !== exp_b.last || out_err !== exp_b.err) begin
            errors++;
            $display("FAIL beat%0d got rgba=%h en=%b last=%b err=%b want rgba=%h en=%b last=%b err=%b",
                     beat_no, out_rgba, out_lane_en, out_last, out_err, exp_b.rgba, exp_b.en, exp_b.last, exp_b.err);
          end
        end
        beat_no++;
      end
      stall_prev = out_valid && !out_ready;
      held = {out_valid, out_rgba, out_lane_en, out_last, out_err};
    end
  end

  // Present a word until accepted; reports whether acceptance coincided with a last-beat handshake.
  task automatic send_word(input logic [127:0] w, input logic [4:0] f, input int fi, input int cn, output bit acc_last);
    bit got;
    got = 1'b0; acc_last = 1'b0;
    in_valid = 1'b1; in_data = w; in_format = f;
    in_first = IDX_W'(fi); in_count = IDX_W'(cn);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_ready) begin
        push_expected(w, f, fi & 31, cn & 31);
        acc_last = out_valid && out_ready && out_last;
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL send_word timeout got in_ready=0 want 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !out_valid) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL drain got pending=%0d out_valid=%b want 0 0", sb.size(), out_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", out_valid); end
    checks++; if (out_rgba !== '0) begin errors++; $display("FAIL rst_rgba got %h want 0", out_rgba); end
    checks++; if (out_lane_en !== '0) begin errors++; $display("FAIL rst_lane_en got %b want 0", out_lane_en); end
    checks++; if (out_last !== 1'b0 || out_err !== 1'b0) begin errors++; $display("FAIL rst_last_err got %b%b want 00", out_last, out_err); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_rgba32();
    bit al;
    out_ready = 1'b1;
    send_word({32'h00FF00FF, 32'hDEADBEEF, 32'h04030201, 32'h80402010}, 5'b00100, 0, 4, al);
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rgba32_latency got valid=%b want 1", out_valid); end
    checks++; if (out_rgba[31:0] !== 32'h80402010) begin errors++; $display("FAIL rgba32_lane0 got %h want 80402010", out_rgba[31:0]); end
    checks++; if (out_lane_en !== 4'hF || out_last !== 1'b1 || out_err !== 1'b0) begin
      errors++; $display("FAIL rgba32_flags got en=%b last=%b err=%b want 1111 1 0", out_lane_en, out_last, out_err); end
    drain();
  endtask

  task automatic test_decode16();
    bit al;
    out_ready = 1'b1;
    send_word({96'h0, 16'h07E0, 16'hF800}, 5'b00001, 0, 2, al);
    @(negedge clk);
    checks++; if (out_rgba[63:0] !== 64'hFF00FF00_FFFF0000 || out_lane_en !== 4'b0011) begin
      errors++; $display("FAIL rgb565 got %h en=%b want ff00ff00ffff0000 en=0011", out_rgba[63:0], out_lane_en); end
    drain();
    send_word({96'h0, 16'h001F, 16'h801F}, 5'b01101, 0, 2, al);
    @(negedge clk);
    checks++; if (out_rgba[63:0] !== 64'h000000FF_FF0000FF) begin
      errors++; $display("FAIL rgba1555 got %h want 000000ffff0000ff", out_rgba[63:0]); end
    drain();
    send_word({$urandom, $urandom, $urandom, $urandom}, 5'b00101, 0, 8, al);
    send_word({$urandom, $urandom, $urandom, $urandom}, 5'b01001, 1, 6, al);
    send_word({$urandom, $urandom, $urandom, $urandom}, 5'b10111, 2, 5, al);
    send_word({$urandom, $urandom, $urandom, $urandom}, 5'b01111, 3, 5, al);
    send_word({$urandom, $urandom, $urandom, $urandom}, 5'b00011, 0, 5, al);
    drain();
  endtask

  task automatic test_clamp();
    bit al;
    out_ready = 1'b1;
    send_word({$urandom, $urandom, $urandom, $urandom}, 5'b00000, 2, 5, al);
    @(negedge clk);
    checks++; if (out_lane_en !== 4'b0111 || out_err !== 1'b1 || out_last !== 1'b1) begin
      errors++; $display("FAIL clamp24 got en=%b err=%b last=%b want 0111 1 1", out_lane_en, out_err, out_last); end
    drain();
    send_word({$urandom, $urandom, $urandom, $urandom}, 5'b00000, 5, 1, al);
    @(negedge clk);
    checks++; if (out_lane_en !== 4'b0000 || out_err !== 1'b1 || out_rgba !== '0) begin
      errors++; $display("FAIL first_oob got en=%b err=%b rgba=%h want 0000 1 0", out_lane_en, out_err, out_rgba); end
    drain();
    send_word({$urandom, $urandom, $urandom, $urandom}, 5'b00100, 3, 4, al);
    send_word({$urandom, $urandom, $urandom, $urandom}, 5'b10011, 10, 9, al);
    drain();
  endtask

  task automatic test_unsupported();
    bit al;
    out_ready = 1'b1;
    send_word({$urandom, $urandom, $urandom, $urandom}, 5'b00010, 0, 4, al);
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_lane_en !== 4'b0000 || out_err !== 1'b1 || out_last !== 1'b1 || out_rgba !== '0) begin
      errors++; $display("FAIL unsupported got v=%b en=%b err=%b last=%b rgba=%h want 1 0000 1 1 0",
                         out_valid, out_lane_en, out_err, out_last, out_rgba); end
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL unsupported_ready got in_ready=%b valid=%b want 1 0", in_ready, out_valid); end
    send_word({$urandom, $urandom, $urandom, $urandom}, 5'b00001, 0, 0, al);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL count0 got valid=%b in_ready=%b want 0 1", out_valid, in_ready); end
    drain();
  endtask

  task automatic test_back_to_back();
    bit al_a, al_b;
    out_ready = 1'b0;
    send_word({$urandom, $urandom, $urandom, $urandom}, 5'b10011, 0, 12, al_a);
    fork
      begin
        send_word({$urandom, $urandom, $urandom, $urandom}, 5'b00001, 1, 3, al_b);
        checks++; if (al_b !== 1'b1) begin errors++; $display("FAIL b2b_accept_on_last got %b want 1", al_b); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_lane_en !== 4'b0111) begin
          errors++; $display("FAIL b2b_no_bubble got valid=%b en=%b want 1 0111", out_valid, out_lane_en); end
      end
      begin
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
  endtask

  task automatic test_reset_midword();
    bit al;
    logic [127:0] w2;
    out_ready = 1'b0;
    send_word({$urandom, $urandom, $urandom, $urandom}, 5'b10011, 0, 8, al);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL async_rst got valid=%b want 0", out_valid); end
    checks++; if (sb.size() != 1) begin errors++; $display("FAIL rst_pending got %0d want 1", sb.size()); end
    sb.delete();
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL post_rst got in_ready=%b valid=%b want 1 0", in_ready, out_valid); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    w2 = {$urandom, $urandom, $urandom, $urandom};
    send_word(w2, 5'b10011, 3, 2, al);
    @(negedge clk);
    checks++; if (out_rgba[31:0] !== {8'hFF, 16'h0000, w2[31:24]} || out_lane_en !== 4'b0011) begin
      errors++; $display("FAIL post_rst_word got %h en=%b want %h en=0011", out_rgba[31:0], out_lane_en, {8'hFF, 16'h0000, w2[31:24]}); end
    drain();
  endtask

  task automatic test_random();
    bit al, done;
    logic [4:0] fmts [0:13];
    fmts = '{5'b00000, 5'b00011, 5'b00100, 5'b00111, 5'b00001, 5'b01011, 5'b00101,
             5'b01111, 5'b01001, 5'b01101, 5'b10011, 5'b10111, 5'b00010, 5'b11110};
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++)
          send_word({$urandom, $urandom, $urandom, $urandom}, fmts[$urandom_range(0, 13)],
                    $urandom_range(0, 17), $urandom_range(0, 20), al);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain();
  endtask

  initial begin
    test_reset();
    test_rgba32();
    test_decode16();
    test_clamp();
    test_unsupported();
    test_back_to_back();
    test_reset_midword();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
